cond_exec_unit: RTL

Parametrised successor to the processor's conditional-execution logic, for the multicycle datapath.
- Holds NZCV flags in N_CTX banked contexts (for example normal and interrupt).
- Evaluates the 4-bit condition once per instruction and latches the result for the instruction's whole duration.
- Gates PC, register and memory write strobes.
- Bypasses same-cycle flag writes into the evaluation.
- Counts annulled instructions.
- Sits between the main decoder/controller FSM and the datapath.

---
 rtl/cond_pkg.sv | 27 ++
 rtl/cond_check.sv | 38 +++
 rtl/cond_exec_unit.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/cond_pkg.sv
// Shared types and constants for the conditional-execution unit.
// Optional feature macro: COND_IT_BLOCK_EN (predicated IT blocks).
package cond_pkg;

    typedef enum logic [3:0] {
        EQ = 4'b0000, NE = 4'b0001, CS = 4'b0010, CC = 4'b0011,
        MI = 4'b0100, PL = 4'b0101, VS = 4'b0110, VC = 4'b0111,
        HI = 4'b1000, LS = 4'b1001, GE = 4'b1010, LT = 4'b1011,
        GT = 4'b1100, LE = 4'b1101, AL = 4'b1110, NV = 4'b1111
    } cond_e;

    // Bit positions inside a {N,Z,C,V} flag nibble
    localparam int unsigned N_IDX = 3;
    localparam int unsigned Z_IDX = 2;
    localparam int unsigned C_IDX = 1;
    localparam int unsigned V_IDX = 0;

    // flag_w bit that enables each flag group
    localparam int unsigned GRP_NZ = 1;
    localparam int unsigned GRP_CV = 0;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_e;

endpackage

// File: rtl/cond_check.sv
// Pure combinational ARM condition-code evaluation on {N,Z,C,V}.
module cond_check (
    input  logic [3:0] cond_i,
    input  logic [3:0] flags_i,
    output logic       pass_o
);
    import cond_pkg::*;

    logic n, z, c, v;

    assign n = flags_i[N_IDX];
    assign z = flags_i[Z_IDX];
    assign c = flags_i[C_IDX];
    assign v = flags_i[V_IDX];

    // Decode the condition field against the supplied flags
    always_comb begin
        pass_o = 1'b1;
        case (cond_e'(cond_i))
            EQ: pass_o = z;
            NE: pass_o = ~z;
            CS: pass_o = c;
            CC: pass_o = ~c;
            MI: pass_o = n;
            PL: pass_o = ~n;
            VS: pass_o = v;
            VC: pass_o = ~v;
            HI: pass_o = c & ~z;
            LS: pass_o = ~c | z;
            GE: pass_o = (n == v);
            LT: pass_o = (n != v);
            GT: pass_o = ~z & (n == v);
            LE: pass_o = z | (n != v);
            default: pass_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/cond_exec_unit.sv
// Conditional-execution unit for the multicycle datapath: banked NZCV flags,
// per-instruction latched condition, gated write strobes, annul counter.
// Optional feature macro: COND_IT_BLOCK_EN (predicated IT blocks).
module cond_exec_unit #(
    parameter int unsigned N_CTX  = 2,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned MAX_IT = 4
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     instr_valid,
    input  logic                                     instr_done,
    input  logic [3:0]                               cond,
    input  logic [((N_CTX > 1) ? $clog2(N_CTX) : 1)-1:0] ctx_sel,
    input  logic [3:0]                               alu_flags,
    input  logic [1:0]                               flag_w,
    input  logic                                     pcs,
    input  logic                                     reg_w,
    input  logic                                     mem_w,
    input  logic                                     no_write,
    input  logic                                     it_start,
    input  logic [$clog2(MAX_IT):0]                  it_len,
    input  logic [3:0]                               it_cond,
    output logic                                     pc_src,
    output logic                                     reg_write,
    output logic                                     mem_write,
    output logic                                     cond_ex,
    output logic [3:0]                               flags_q,
    output logic                                     busy,
    output logic [CNT_W-1:0]                         annul_cnt,
    output logic                                     it_active
);
    import cond_pkg::*;

    localparam int unsigned IT_W = $clog2(MAX_IT) + 1;

    state_e           state_q, state_d;
    logic [3:0]       bank_q [N_CTX];
    logic [3:0]       bank_d [N_CTX];
    logic             cond_ex_q, cond_ex_d;
    logic [CNT_W-1:0] annul_q, annul_d;
    logic [3:0]       bank_flags;
    logic [3:0]       eval_flags;
    logic [3:0]       eff_cond;
    logic             eval_pass;
    logic             active;

    assign bank_flags = bank_q[ctx_sel];
    assign flags_q    = bank_flags;
    assign busy       = (state_q == EXEC);
    assign active     = busy | instr_valid;
    assign annul_cnt  = annul_q;

    // Bypass keys off the raw flag_w request rather than the gated write,
    // since the gate itself depends on this evaluation.
    assign eval_flags = {flag_w[GRP_NZ] ? alu_flags[3:2] : bank_flags[3:2],
                         flag_w[GRP_CV] ? alu_flags[1:0] : bank_flags[1:0]};

    cond_check u_cond_check (
        .cond_i  (eff_cond),
        .flags_i (eval_flags),
        .pass_o  (eval_pass)
    );

    assign cond_ex   = instr_valid ? eval_pass : (busy ? cond_ex_q : 1'b0);
    assign reg_write = active & reg_w & cond_ex & ~no_write;
    assign mem_write = active & mem_w & cond_ex;
    assign pc_src    = active & pcs & cond_ex;

`ifdef COND_IT_BLOCK_EN
    logic [IT_W-1:0] it_cnt_q, it_cnt_d;
    logic [3:0]      it_cond_q, it_cond_d;

    assign it_active = (it_cnt_q != '0);
    assign eff_cond  = it_active ? it_cond_q : cond;

    // IT counter: a fresh it_start wins over the decrement of the current slot
    always_comb begin
        it_cnt_d  = it_cnt_q;
        it_cond_d = it_cond_q;
        if (instr_valid && it_active) begin
            it_cnt_d = it_cnt_q - IT_W'(1);
        end
        if (it_start) begin
            it_cond_d = it_cond;
            if (it_len == '0) begin
                it_cnt_d = IT_W'(1);
            end else if (it_len > IT_W'(MAX_IT)) begin
                it_cnt_d = IT_W'(MAX_IT);
            end else begin
                it_cnt_d = it_len;
            end
        end
    end

    // IT block state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            it_cnt_q  <= '0;
            it_cond_q <= '0;
        end else begin
            it_cnt_q  <= it_cnt_d;
            it_cond_q <= it_cond_d;
        end
    end
`else
    logic unused_it;

    assign unused_it = ^{it_start, it_len, it_cond};
    assign it_active = 1'b0;
    assign eff_cond  = cond;
`endif

    // Next state, latched condition, flag bank update and annul counter
    always_comb begin
        state_d   = state_q;
        cond_ex_d = cond_ex_q;
        annul_d   = annul_q;
        bank_d    = bank_q;
        case (state_q)
            IDLE: if (instr_valid) state_d = EXEC;
            EXEC: if (!instr_valid && instr_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (instr_valid) begin
            cond_ex_d = eval_pass;
            if (!eval_pass && (annul_q != '1)) begin
                annul_d = annul_q + CNT_W'(1);
            end
        end
        if (active && cond_ex) begin
            if (flag_w[GRP_NZ]) begin
                bank_d[ctx_sel][N_IDX] = alu_flags[N_IDX];
                bank_d[ctx_sel][Z_IDX] = alu_flags[Z_IDX];
            end
            if (flag_w[GRP_CV]) begin
                bank_d[ctx_sel][C_IDX] = alu_flags[C_IDX];
                bank_d[ctx_sel][V_IDX] = alu_flags[V_IDX];
            end
        end
    end

    // State, condition, counter and flag bank registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cond_ex_q <= 1'b0;
            annul_q   <= '0;
            for (int unsigned i = 0; i < N_CTX; i++) begin
                bank_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cond_ex_q <= cond_ex_d;
            annul_q   <= annul_d;
            bank_q    <= bank_d;
        end
    end

endmodule
